mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: a Moore FSM that steps each instruction through
// fetch, decode, execute/memory, and writeback. It drives datapath enables and selects.
module mc_ctrl #(
    parameter int unsigned IF_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic        pcwr,
    output logic        irwr,
    output logic [1:0]  npc_sel,
    output logic        regwr,
    output logic [1:0]  regdst,
    output logic [1:0]  wdsel,
    output logic        alusrc,
    output logic [1:0]  aluop,
    output logic        extop,
    output logic        memwr,
    output logic        ncond,
    output logic        illegal,
    output logic [3:0]  state
);
    localparam logic [3:0] S_IF  = 4'd0;
    localparam logic [3:0] S_DCD = 4'd1;
    localparam logic [3:0] S_EXE = 4'd2;
    localparam logic [3:0] S_WB  = 4'd3;
    localparam logic [3:0] S_MA  = 4'd4;
    localparam logic [3:0] S_MR  = 4'd5;
    localparam logic [3:0] S_MW  = 4'd6;
    localparam logic [3:0] S_LWB = 4'd7;
    localparam logic [3:0] S_BR  = 4'd8;
    localparam logic [3:0] S_JMP = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] WAIT_LAST = IF_WAIT[3:0];

    logic [3:0] state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [5:0] op_reg, funct_reg;

    logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_jr;
    logic fetch_done;
    logic [1:0] aluop_dec;
    logic alusrc_dec, extop_dec;

    // Everything after fetch decodes from the latched copy, so instr may change freely.
    assign is_addu = (op_reg == OP_RTYPE) && (funct_reg == FN_ADDU);
    assign is_subu = (op_reg == OP_RTYPE) && (funct_reg == FN_SUBU);
    assign is_jr   = (op_reg == OP_RTYPE) && (funct_reg == FN_JR);
    assign is_ori  = (op_reg == OP_ORI);
    assign is_lui  = (op_reg == OP_LUI);
    assign is_lw   = (op_reg == OP_LW);
    assign is_sw   = (op_reg == OP_SW);
    assign is_beq  = (op_reg == OP_BEQ);
    assign is_j    = (op_reg == OP_J);
    assign is_jal  = (op_reg == OP_JAL);

    assign fetch_done = (state_reg == S_IF) && (cnt_reg == WAIT_LAST);

    assign aluop_dec  = (is_subu || is_beq) ? 2'b01 :
                        is_ori ? 2'b10 :
                        is_lui ? 2'b11 : 2'b00;
    assign alusrc_dec = is_ori || is_lui || is_lw || is_sw;
    assign extop_dec  = is_lw || is_sw || is_beq;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IF: begin
                if (fetch_done) begin
                    state_next = S_DCD;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_DCD: begin
                if (is_addu || is_subu || is_ori || is_lui) state_next = S_EXE;
                else if (is_lw || is_sw)                    state_next = S_MA;
                else if (is_beq)                            state_next = S_BR;
                else if (is_j || is_jal || is_jr)           state_next = S_JMP;
                else                                        state_next = S_IF;
            end
            S_EXE:   state_next = S_WB;
            S_MA:    state_next = is_lw ? S_MR : S_MW;
            S_MR:    state_next = S_LWB;
            default: state_next = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IF;
            cnt_reg   <= 4'd0;
            op_reg    <= 6'd0;
            funct_reg <= 6'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (fetch_done) begin
                op_reg    <= instr[31:26];
                funct_reg <= instr[5:0];
            end
        end
    end

    always_comb begin
        pcwr    = 1'b0;
        irwr    = 1'b0;
        npc_sel = 2'b00;
        regwr   = 1'b0;
        regdst  = 2'b00;
        wdsel   = 2'b00;
        alusrc  = 1'b0;
        aluop   = 2'b00;
        extop   = 1'b0;
        memwr   = 1'b0;
        illegal = 1'b0;
        case (state_reg)
            // Gated by rst so a zero-wait fetch does not assert irwr while held in reset.
            S_IF:  irwr = fetch_done && !rst;
            S_DCD: illegal = !(is_addu || is_subu || is_ori || is_lui || is_lw || is_sw ||
                               is_beq || is_j || is_jal || is_jr);
            S_EXE, S_MA, S_MR: begin
                alusrc = alusrc_dec;
                aluop  = aluop_dec;
                extop  = extop_dec;
            end
            S_WB: begin
                pcwr   = 1'b1;
                regwr  = 1'b1;
                regdst = (is_addu || is_subu) ? 2'b01 : 2'b00;
                alusrc = alusrc_dec;
                aluop  = aluop_dec;
                extop  = extop_dec;
            end
            S_LWB: begin
                pcwr   = 1'b1;
                regwr  = 1'b1;
                wdsel  = 2'b01;
                alusrc = alusrc_dec;
                aluop  = aluop_dec;
                extop  = extop_dec;
            end
            S_MW: begin
                pcwr   = 1'b1;
                memwr  = 1'b1;
                alusrc = alusrc_dec;
                aluop  = aluop_dec;
                extop  = extop_dec;
            end
            S_BR: begin
                pcwr    = 1'b1;
                npc_sel = 2'b01;
                aluop   = aluop_dec;
                extop   = extop_dec;
            end
            S_JMP: begin
                pcwr    = 1'b1;
                npc_sel = is_jr ? 2'b11 : 2'b10;
                if (is_jal) begin
                    regwr  = 1'b1;
                    regdst = 2'b10;
                    wdsel  = 2'b10;
                end
            end
            default: ;
        endcase
    end

    assign ncond = 1'b0;
    assign state = state_reg;
endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: random instructions compared cycle by cycle against a
// table-driven model of the state path and control outputs of each instruction class.
module tb_mc_ctrl;
    localparam int W = 2;

    localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3, C_LW = 4, C_SW = 5;
    localparam int C_BEQ = 6, C_J = 7, C_JAL = 8, C_JR = 9, C_ILL = 10;

    logic        clk, rst;
    logic [31:0] instr;
    logic        pcwr, irwr, regwr, alusrc, extop, memwr, ncond, illegal;
    logic [1:0]  npc_sel, regdst, wdsel, aluop;
    logic [3:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    mc_ctrl #(.IF_WAIT(W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pcwr(pcwr), .irwr(irwr), .npc_sel(npc_sel),
        .regwr(regwr), .regdst(regdst), .wdsel(wdsel), .alusrc(alusrc), .aluop(aluop),
        .extop(extop), .memwr(memwr), .ncond(ncond), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] act();
        return {state, pcwr, irwr, npc_sel, regwr, regdst, wdsel, alusrc, aluop,
                extop, memwr, ncond, illegal};
    endfunction

    // Instruction table: opcode/funct to class.
    function automatic int classify(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b100001) ? C_ADDU : (fn == 6'b100011) ? C_SUBU :
                              (fn == 6'b001000) ? C_JR : C_ILL;
            6'b001101: return C_ORI;
            6'b001111: return C_LUI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic logic [31:0] make_instr(int cls);
        logic [31:0] r;
        r = $urandom;
        case (cls)
            C_ADDU: begin r[31:26] = 6'b000000; r[5:0] = 6'b100001; end
            C_SUBU: begin r[31:26] = 6'b000000; r[5:0] = 6'b100011; end
            C_JR:   begin r[31:26] = 6'b000000; r[5:0] = 6'b001000; end
            C_ORI:  r[31:26] = 6'b001101;
            C_LUI:  r[31:26] = 6'b001111;
            C_LW:   r[31:26] = 6'b100011;
            C_SW:   r[31:26] = 6'b101011;
            C_BEQ:  r[31:26] = 6'b000100;
            C_J:    r[31:26] = 6'b000010;
            C_JAL:  r[31:26] = 6'b000011;
            default: begin
                if ($urandom_range(0, 1) == 0) r[31:26] = 6'b111111;
                else r[31:26] = 6'b000000;
                while (classify(r[31:26], r[5:0]) != C_ILL) r[5:0] = 6'($urandom);
            end
        endcase
        return r;
    endfunction

    // Expected outputs from the per-state rules of the control table.
    function automatic logic [19:0] exp_out(int cls, int st, bit fetch_last);
        logic       e_pcwr, e_irwr, e_regwr, e_alusrc, e_extop, e_memwr, e_ill;
        logic [1:0] e_npc, e_regdst, e_wdsel, e_aluop;
        bit         in_alu;
        e_pcwr   = (st == 3 || st == 6 || st == 7 || st == 8 || st == 9);
        e_irwr   = (st == 0) && fetch_last;
        e_npc    = (st == 8) ? 2'b01 : (st == 9) ? ((cls == C_JR) ? 2'b11 : 2'b10) : 2'b00;
        e_regwr  = (st == 3 || st == 7 || (st == 9 && cls == C_JAL));
        e_regdst = (st == 3 && (cls == C_ADDU || cls == C_SUBU)) ? 2'b01 :
                   (st == 9 && cls == C_JAL) ? 2'b10 : 2'b00;
        e_wdsel  = (st == 7) ? 2'b01 : (st == 9 && cls == C_JAL) ? 2'b10 : 2'b00;
        in_alu   = (st >= 2 && st <= 8);
        e_alusrc = in_alu && st != 8 &&
                   (cls == C_ORI || cls == C_LUI || cls == C_LW || cls == C_SW);
        e_aluop  = !in_alu ? 2'b00 : (cls == C_SUBU || cls == C_BEQ) ? 2'b01 :
                   (cls == C_ORI) ? 2'b10 : (cls == C_LUI) ? 2'b11 : 2'b00;
        e_extop  = in_alu && (cls == C_LW || cls == C_SW || cls == C_BEQ);
        e_memwr  = (st == 6);
        e_ill    = (st == 1) && (cls == C_ILL);
        return {4'(st), e_pcwr, e_irwr, e_npc, e_regwr, e_regdst, e_wdsel, e_alusrc,
                e_aluop, e_extop, e_memwr, 1'b0, e_ill};
    endfunction

    // Called at a falling edge with the DUT at the start of a fetch; returns at the next one.
    task automatic run_instr(int cls, string tag);
        int path[$];
        logic [19:0] e, a;
        for (int i = 0; i <= W; i++) path.push_back(0);
        path.push_back(1);
        case (cls)
            C_ADDU, C_SUBU, C_ORI, C_LUI: begin path.push_back(2); path.push_back(3); end
            C_LW:  begin path.push_back(4); path.push_back(5); path.push_back(7); end
            C_SW:  begin path.push_back(4); path.push_back(6); end
            C_BEQ: path.push_back(8);
            C_J, C_JAL, C_JR: path.push_back(9);
            default: ;
        endcase
        instr = make_instr(cls);
        $display("txn %s class=%0d instr=%h cycles=%0d", tag, cls, instr, path.size());
        for (int i = 0; i < path.size(); i++) begin
            #1;
            e = exp_out(cls, path[i], i == W);
            a = act();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %b expected %b", tag, i, a, e);
            end
            if (i > W) instr = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        instr = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (act() !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected %b", act(), 20'h0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_addu();    run_instr(C_ADDU, "addu");       endtask
    task automatic test_lw();      run_instr(C_LW, "lw");           endtask
    task automatic test_sw();      run_instr(C_SW, "sw");           endtask
    task automatic test_beq();     run_instr(C_BEQ, "beq");         endtask
    task automatic test_jumps();
        run_instr(C_JAL, "jal");
        run_instr(C_JR, "jr");
        run_instr(C_J, "j");
    endtask
    task automatic test_alu_imm();
        run_instr(C_SUBU, "subu");
        run_instr(C_ORI, "ori");
        run_instr(C_LUI, "lui");
    endtask
    task automatic test_illegal(); run_instr(C_ILL, "illegal");     endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) run_instr($urandom_range(0, 10), "random");
    endtask

    task automatic test_mid_reset();
        logic [19:0] e;
        instr = make_instr(C_LW);
        $display("txn mid_reset lw instr=%h", instr);
        for (int i = 0; i <= W + 3; i++) begin
            #1;
            e = (i <= W) ? exp_out(C_LW, 0, i == W) :
                (i == W + 1) ? exp_out(C_LW, 1, 0) :
                (i == W + 2) ? exp_out(C_LW, 4, 0) : exp_out(C_LW, 5, 0);
            n_checks++;
            if (act() !== e) begin
                n_fail++;
                $display("FAIL mid_reset_path cycle %0d: got %b expected %b", i, act(), e);
            end
            if (i < W + 3) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (act() !== 20'h0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %b expected %b", act(), 20'h0);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (act() !== 20'h0) begin
            n_fail++;
            $display("FAIL mid_reset_held: got %b expected %b", act(), 20'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        run_instr(C_LW, "refetch_lw");
        run_instr($urandom_range(0, 10), "refetch_random");
    endtask

    initial begin
        rst   = 1'b1;
        instr = 32'h0;
        test_reset();
        test_addu();
        test_lw();
        test_sw();
        test_beq();
        test_jumps();
        test_alu_imm();
        test_illegal();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
